// File: rtl/seq_divider_if.sv
// Operand/result bundle for seq_divider: the requester drives START/DATA1/DATA2
// as master, and the divider returns results and status as slave.
interface seq_divider_if #(
  parameter int WIDTH = 8
);
  logic             START;
  logic [WIDTH-1:0] DATA1;
  logic [WIDTH-1:0] DATA2;
  logic [WIDTH-1:0] QUOTIENT;
  logic [WIDTH-1:0] REMAINDER;
  logic             BUSY;
  logic             DONE;
  logic             DIV_ZERO;

  modport master (
    output START, DATA1, DATA2,
    input  QUOTIENT, REMAINDER, BUSY, DONE, DIV_ZERO
  );

  modport slave (
    input  START, DATA1, DATA2,
    output QUOTIENT, REMAINDER, BUSY, DONE, DIV_ZERO
  );
endinterface

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per clock; START sampled in IDLE, results + DONE 9 edges later.
// Busy operations ignore START (no queueing). Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands.
module seq_divider #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input logic         CLK,
  input logic         RESET,
  seq_divider_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] acc, acc_nx;
  logic [WIDTH-1:0] q, q_nx;
  logic [WIDTH-1:0] dvs, dvs_nx;
  logic [WIDTH-1:0] raw, raw_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             dz, dz_nx;
  logic             q_neg, q_neg_nx;
  logic             r_neg, r_neg_nx;
  logic [WIDTH-1:0] quo, quo_nx;
  logic [WIDTH-1:0] rem, rem_nx;
  logic             dz_out, dz_out_nx;
  logic             busy, busy_nx;
  logic             done, done_nx;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   acc_sh, trial;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= IDLE;
      acc    <= '0;
      q      <= '0;
      dvs    <= '0;
      raw    <= '0;
      cnt    <= '0;
      dz     <= 1'b0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      quo    <= '0;
      rem    <= '0;
      dz_out <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nx;
      acc    <= acc_nx;
      q      <= q_nx;
      dvs    <= dvs_nx;
      raw    <= raw_nx;
      cnt    <= cnt_nx;
      dz     <= dz_nx;
      q_neg  <= q_neg_nx;
      r_neg  <= r_neg_nx;
      quo    <= quo_nx;
      rem    <= rem_nx;
      dz_out <= dz_out_nx;
      busy   <= busy_nx;
      done   <= done_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    acc_nx    = acc;
    q_nx      = q;
    dvs_nx    = dvs;
    raw_nx    = raw;
    cnt_nx    = cnt;
    dz_nx     = dz;
    q_neg_nx  = q_neg;
    r_neg_nx  = r_neg;
    quo_nx    = quo;
    rem_nx    = rem;
    dz_out_nx = dz_out;
    busy_nx   = busy;
    done_nx   = 1'b0;
    mag_a     = bus.DATA1;
    mag_b     = bus.DATA2;
    acc_sh    = {acc, q[WIDTH-1]};
    // acc < dvs always holds, so the 9-bit difference's MSB is a valid sign bit
    trial     = acc_sh - {1'b0, dvs};

    unique case (state)
      IDLE: begin
        if (bus.START) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
          // -128 maps to 8'h80, which is also its unsigned magnitude
          mag_a    = bus.DATA1[WIDTH-1] ? -bus.DATA1 : bus.DATA1;
          mag_b    = bus.DATA2[WIDTH-1] ? -bus.DATA2 : bus.DATA2;
          q_neg_nx = bus.DATA1[WIDTH-1] ^ bus.DATA2[WIDTH-1];
          r_neg_nx = bus.DATA1[WIDTH-1];
`else
          q_neg_nx = 1'b0;
          r_neg_nx = 1'b0;
`endif
          raw_nx   = bus.DATA1;
          dz_nx    = (bus.DATA2 == '0);
          acc_nx   = '0;
          q_nx     = mag_a;
          dvs_nx   = mag_b;
          cnt_nx   = CNT_W'(WIDTH - 1);
          busy_nx  = 1'b1;
          state_nx = CALC;
        end
      end
      CALC: begin
        if (!trial[WIDTH]) begin
          acc_nx = trial[WIDTH-1:0];
          q_nx   = {q[WIDTH-2:0], 1'b1};
        end else begin
          acc_nx = acc_sh[WIDTH-1:0];
          q_nx   = {q[WIDTH-2:0], 1'b0};
        end
        if (cnt == '0) state_nx = FIX;
        else           cnt_nx   = cnt - CNT_W'(1);
      end
      FIX: begin
        if (dz) begin
          quo_nx    = '1;
          rem_nx    = raw;
          dz_out_nx = 1'b1;
        end else begin
          quo_nx    = q_neg ? -q : q;
          rem_nx    = r_neg ? -acc : acc;
          dz_out_nx = 1'b0;
        end
        done_nx  = 1'b1;
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.QUOTIENT  = quo;
  assign bus.REMAINDER = rem;
  assign bus.DIV_ZERO  = dz_out;
  assign bus.BUSY      = busy;
  assign bus.DONE      = done;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: latency, results, divide-by-zero, handshake, reset abort.
module tb_seq_divider;

  logic CLK;
  logic RESET;
  int   n_assert = 0;
  int   n_fail   = 0;

  seq_divider_if #(.WIDTH(8)) bus ();

  seq_divider #(.WIDTH(8), .CNT_W(3)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Launch one op, then step through the 8 CALC edges and the FIX edge
  task automatic do_op(input string name, input logic [7:0] a, input logic [7:0] b,
                       input bit scramble, input bit repulse);
    logic early;
    bus.START = 1'b1;
    bus.DATA1 = a;
    bus.DATA2 = b;
    tick();
    bus.START = 1'b0;
    chk({name, "_busy_start"}, 8'(bus.BUSY), 8'd1);
    early = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (scramble) begin
        bus.DATA1 = 8'($urandom);
        bus.DATA2 = 8'($urandom);
      end
      bus.START = repulse && (i == 3 || i == 5);
      tick();
      if (bus.DONE || !bus.BUSY) early = 1'b1;
    end
    bus.START = 1'b0;
    chk({name, "_early_done"}, 8'(early), 8'd0);
    tick();
    chk({name, "_done"}, 8'(bus.DONE), 8'd1);
    chk({name, "_busy_done"}, 8'(bus.BUSY), 8'd0);
  endtask

  task automatic res(input string name, input logic [7:0] eq, input logic [7:0] er, input logic ez);
    chk({name, "_quotient"}, bus.QUOTIENT, eq);
    chk({name, "_remainder"}, bus.REMAINDER, er);
    chk({name, "_div_zero"}, 8'(bus.DIV_ZERO), 8'(ez));
  endtask

  task automatic after_done(input string name);
    tick();
    chk({name, "_done_clear"}, 8'(bus.DONE), 8'd0);
    chk({name, "_idle"}, 8'(bus.BUSY), 8'd0);
  endtask

  initial begin
    logic seen;
    RESET     = 1'b1;
    bus.START = 1'b0;
    bus.DATA1 = '0;
    bus.DATA2 = '0;
    repeat (2) tick();
    res("reset", 8'h00, 8'h00, 1'b0);
    chk("reset_busy", 8'(bus.BUSY), 8'd0);
    chk("reset_done", 8'(bus.DONE), 8'd0);
    RESET = 1'b0;
    tick();

    do_op("d100_7", 8'd100, 8'd7, 1'b0, 1'b0);
    res("d100_7", 8'd14, 8'd2, 1'b0);
    after_done("d100_7");

    do_op("dz", 8'h5A, 8'h00, 1'b0, 1'b0);
    res("dz", 8'hFF, 8'h5A, 1'b1);
    after_done("dz");

    do_op("d9_3", 8'd9, 8'd3, 1'b0, 1'b0);
    res("d9_3", 8'd3, 8'd0, 1'b0);

    do_op("d255_16", 8'd255, 8'd16, 1'b0, 1'b0);
    res("d255_16", 8'd15, 8'd15, 1'b0);

    do_op("d7_9", 8'd7, 8'd9, 1'b0, 1'b0);
    res("d7_9", 8'd0, 8'd7, 1'b0);

    do_op("d200_1", 8'd200, 8'd1, 1'b0, 1'b0);
    res("d200_1", 8'd200, 8'd0, 1'b0);

`ifdef SEQ_DIVIDER_SIGNED_EN
    do_op("s_m7_2", 8'hF9, 8'h02, 1'b0, 1'b0);
    res("s_m7_2", 8'hFD, 8'hFF, 1'b0);
    do_op("s_7_m2", 8'h07, 8'hFE, 1'b0, 1'b0);
    res("s_7_m2", 8'hFD, 8'h01, 1'b0);
    do_op("s_m128_m1", 8'h80, 8'hFF, 1'b0, 1'b0);
    res("s_m128_m1", 8'h80, 8'h00, 1'b0);
`else
    do_op("u_249_2", 8'hF9, 8'h02, 1'b0, 1'b0);
    res("u_249_2", 8'h7C, 8'h01, 1'b0);
    do_op("u_7_254", 8'h07, 8'hFE, 1'b0, 1'b0);
    res("u_7_254", 8'h00, 8'h07, 1'b0);
    do_op("u_128_255", 8'h80, 8'hFF, 1'b0, 1'b0);
    res("u_128_255", 8'h00, 8'h80, 1'b0);
`endif

    do_op("scramble", 8'd77, 8'd6, 1'b1, 1'b0);
    res("scramble", 8'd12, 8'd5, 1'b0);

    do_op("repulse", 8'd250, 8'd25, 1'b0, 1'b1);
    res("repulse", 8'd10, 8'd0, 1'b0);
    after_done("repulse");

    // START held through DONE: second op accepted on the edge ending the DONE cycle
    bus.START = 1'b1;
    bus.DATA1 = 8'd50;
    bus.DATA2 = 8'd5;
    tick();
    seen = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (bus.DONE) seen = 1'b1;
    end
    chk("b2b_first_early", 8'(seen), 8'd0);
    tick();
    chk("b2b_first_done", 8'(bus.DONE), 8'd1);
    res("b2b_first", 8'd10, 8'd0, 1'b0);
    bus.DATA1 = 8'd81;
    bus.DATA2 = 8'd9;
    tick();
    bus.START = 1'b0;
    chk("b2b_second_busy", 8'(bus.BUSY), 8'd1);
    chk("b2b_second_done_low", 8'(bus.DONE), 8'd0);
    seen = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (bus.DONE) seen = 1'b1;
    end
    chk("b2b_second_early", 8'(seen), 8'd0);
    tick();
    chk("b2b_second_done", 8'(bus.DONE), 8'd1);
    res("b2b_second", 8'd9, 8'd0, 1'b0);
    after_done("b2b");

    // Reset at edge N+4 of an operation
    bus.START = 1'b1;
    bus.DATA1 = 8'd123;
    bus.DATA2 = 8'd4;
    tick();
    bus.START = 1'b0;
    repeat (3) tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    res("rst_mid", 8'h00, 8'h00, 1'b0);
    chk("rst_mid_busy", 8'(bus.BUSY), 8'd0);
    chk("rst_mid_done", 8'(bus.DONE), 8'd0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.DONE || bus.BUSY) seen = 1'b1;
    end
    chk("rst_no_done", 8'(seen), 8'd0);

    do_op("post_rst", 8'd200, 8'd10, 1'b0, 1'b0);
    res("post_rst", 8'd20, 8'd0, 1'b0);
    after_done("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
